// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator: FSM states, row idle level,
// LFSR seed and the key-code to matrix-position mapping.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BOUNCE_DN = 3'd1,
    ST_HOLD      = 3'd2,
    ST_BOUNCE_UP = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam int         CNT_W     = 17;
  localparam logic [3:0] ROW_IDLE  = 4'hF;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Returns {row_index[1:0], col_index[1:0]}; index 0 maps to bit 3 of row/col.
  function automatic logic [3:0] key_to_rc(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      4'h0:    rc = {2'd0, 2'd0};
      4'h1:    rc = {2'd0, 2'd1};
      4'h2:    rc = {2'd0, 2'd2};
      4'hC:    rc = {2'd0, 2'd3};
      4'h3:    rc = {2'd1, 2'd0};
      4'h4:    rc = {2'd1, 2'd1};
      4'h5:    rc = {2'd1, 2'd2};
      4'hD:    rc = {2'd1, 2'd3};
      4'h6:    rc = {2'd2, 2'd0};
      4'h7:    rc = {2'd2, 2'd1};
      4'h8:    rc = {2'd2, 2'd2};
      4'hE:    rc = {2'd2, 2'd3};
      4'hA:    rc = {2'd3, 2'd0};
      4'h9:    rc = {2'd3, 2'd1};
      4'hB:    rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Synchronous FIFO holding queued key codes. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate count.
module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; a full queue ignores pushes, an empty one ignores pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix keypad responder. Queued key codes are "pressed" one at a
// time: contact closes for HOLD_CYCLES, then stays open for GAP_CYCLES.
// Optional macro KEYPAD_BOUNCE_EN adds LFSR-driven contact bounce windows of
// BOUNCE_CYCLES before and after each hold period.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50000,
  parameter int GAP_CYCLES    = 50000,
  parameter int FIFO_DEPTH    = 4,
  parameter int BOUNCE_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       pressed,
  output logic [7:0] keys_sent
);

  // Every phase length is loaded as N-1 into a 17-bit down counter.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << CNT_W) ||
      GAP_CYCLES < 1 || GAP_CYCLES > (1 << CNT_W) ||
      BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > (1 << CNT_W)) begin : g_param_err
    $error("keypad_emulator: cycle parameters must lie in 1..131072");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
`ifdef KEYPAD_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [3:0]       cur_key_q;
  logic [7:0]       sent_q;
  logic             pop;
  logic             sent_inc;
  logic             contact;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       fifo_data;
  logic [3:0]       rc;

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (key_valid),
    .pop     (pop),
    .wr_data (key_code),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state logic: each timed phase exits when its down counter reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    sent_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
          state_d = ST_BOUNCE_DN;
          cnt_d   = BOUNCE_LOAD;
`else
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
`endif
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      ST_BOUNCE_DN: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
`endif
      ST_HOLD: begin
        if (cnt_q == '0) begin
`ifdef KEYPAD_BOUNCE_EN
          state_d = ST_BOUNCE_UP;
          cnt_d   = BOUNCE_LOAD;
`else
          state_d  = ST_GAP;
          cnt_d    = GAP_LOAD;
          sent_inc = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      ST_BOUNCE_UP: begin
        if (cnt_q == '0) begin
          state_d  = ST_GAP;
          cnt_d    = GAP_LOAD;
          sent_inc = 1'b1;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
`endif
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, phase counter and completed-press counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sent_inc) sent_q <= sent_q + 8'd1;
    end
  end

  // Current key latches on pop; it only matters while the contact is closed.
  always_ff @(posedge clk) begin
    if (pop) cur_key_q <= fifo_data;
  end

`ifdef KEYPAD_BOUNCE_EN
  logic [7:0] lfsr_q;
  logic       in_bounce;

  assign in_bounce = (state_q == ST_BOUNCE_DN) || (state_q == ST_BOUNCE_UP);
  assign contact   = (state_q == ST_HOLD) || (in_bounce && lfsr_q[0]);

  // Bounce pattern generator, x^8+x^6+x^5+x^4+1, advances only while bouncing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (in_bounce) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end
`else
  assign contact = (state_q == ST_HOLD);
`endif

  assign rc = key_to_rc(cur_key_q);

  // Row sense: the pressed key's row goes low only while its column is driven low.
  always_comb begin
    row = ROW_IDLE;
    if (contact && !col[2'd3 - rc[1:0]]) row[2'd3 - rc[3:2]] = 1'b0;
  end

  assign key_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign pressed   = contact;
  assign keys_sent = sent_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator (HOLD=20, GAP=10, DEPTH=4, BOUNCE=8).
// Reference model tracks press windows as cycle intervals plus a key queue.
module tb_keypad_emulator;

  localparam int H = 20;
  localparam int G = 10;
  localparam int D = 4;
  localparam int B = 8;
`ifdef KEYPAD_BOUNCE_EN
  localparam int BW = B;
`else
  localparam int BW = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       pressed;
  logic [7:0] keys_sent;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G),
    .FIFO_DEPTH    (D),
    .BOUNCE_CYCLES (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .col       (col),
    .row       (row),
    .busy      (busy),
    .pressed   (pressed),
    .keys_sent (keys_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Keypad layout: km[r][c] is the key at row index r, column index c.
  int km [4][4] = '{'{0, 1, 2, 12}, '{3, 4, 5, 13}, '{6, 7, 8, 14}, '{10, 9, 11, 15}};

  // Model state: queue of codes and the cycle intervals of the current press.
  int q[$];
  int cyc         = 0;
  int idle_from   = 0;
  int press_start = -1000000;
  int sent_at     = -1;
  int cur         = 0;
  int m_sent      = 0;
  bit can_pop;
  bit do_push;
  int rel;
  bit in_hold;
  bit in_bounce;
  bit rand_col    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (model cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  function automatic logic [3:0] exp_row(input int key, input logic [3:0] c, input bit closed);
    logic [3:0] r;
    r = 4'hF;
    if (closed) begin
      for (int ri = 0; ri < 4; ri++)
        for (int ci = 0; ci < 4; ci++)
          if (km[ri][ci] == key && c[3-ci] == 1'b0) r[3-ri] = 1'b0;
    end
    return r;
  endfunction

  // Model advance on each active edge, using pre-edge inputs and queue.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      cyc         = 0;
      idle_from   = 0;
      press_start = -1000000;
      sent_at     = -1;
      m_sent      = 0;
    end else begin
      can_pop = (cyc >= idle_from) && (q.size() > 0);
      do_push = key_valid && (q.size() < D);
      cyc++;
      if (can_pop) begin
        cur         = q.pop_front();
        press_start = cyc;
        idle_from   = cyc + 2*BW + H + G;
        sent_at     = cyc + 2*BW + H;
      end
      if (do_push) q.push_back(int'(key_code));
      if (cyc == sent_at) m_sent = (m_sent + 1) % 256;
    end
  end

  // Compare all outputs on the falling edge of every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_row", row, 4'hF);
      chk("rst_pressed", pressed, 0);
      chk("rst_busy", busy, 0);
      chk("rst_keys_sent", keys_sent, 0);
      chk("rst_key_ready", key_ready, 1);
    end else begin
      rel       = cyc - press_start;
      in_hold   = (rel >= BW) && (rel < BW + H);
      in_bounce = ((rel >= 0) && (rel < BW)) || ((rel >= BW + H) && (rel < 2*BW + H));
      if (!in_bounce) begin
        chk("pressed", pressed, in_hold);
        chk("row", row, exp_row(cur, col, in_hold));
      end
      chk("key_ready", key_ready, q.size() < D);
      chk("busy", busy, (cyc < idle_from) || (q.size() > 0));
      chk("keys_sent", keys_sent, m_sent);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      if (rand_col) col = 4'($urandom);
    end
  endtask

  task automatic push(input logic [3:0] k);
    int w;
    bit acc;
    w   = 0;
    acc = 0;
    key_code  = k;
    key_valid = 1'b1;
    while (!acc && w < 2000) begin
      acc = key_ready;
      tick(1);
      w++;
    end
    key_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    while (busy && w < budget) begin
      tick(1);
      w++;
    end
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_pressed(input int budget);
    int w;
    w = 0;
    while (!pressed && w < budget) begin
      tick(1);
      w++;
    end
    chk("wait_pressed", pressed, 1);
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    rst_n     = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  int cnt;

  initial begin
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    col       = 4'hF;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("init_row", row, 4'hF);
    chk("init_key_ready", key_ready, 1);
    chk("init_busy", busy, 0);
    chk("init_keys_sent", keys_sent, 0);

    // Key 5 on column index 2: row index 1 goes low.
    col = 4'b1101;
    push(4'h5);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (row == 4'b1011) cnt++;
    end
`ifndef KEYPAD_BOUNCE_EN
    chk("k5_low_cycles", cnt, 20);
`endif
    wait_idle(200);
    chk("k5_keys_sent", keys_sent, 1);
    chk("k5_row_idle", row, 4'hF);

    // Key 9 with all columns driven, then its column released.
    col = 4'b0000;
    push(4'h9);
    wait_pressed(50);
    tick(BW + 2);
    chk("k9_all_cols", row, 4'b1110);
    col = 4'b0111;
    #1;
    chk("k9_col_off", row, 4'hF);
    chk("k9_still_pressed", pressed, 1);
    col = 4'b0000;
    wait_idle(200);
    chk("k9_keys_sent", keys_sent, 2);

    // Five back-to-back pushes: first is popped, remaining four fill the queue.
    rand_col = 1;
    for (int i = 0; i < 5; i++) push(4'($urandom));
    chk("b2b_ready_low", key_ready, 0);
    wait_idle(1000);
    chk("b2b_keys_sent", keys_sent, 7);
    rand_col = 0;

    // Reset in the middle of a hold period.
    col = 4'b0000;
    push(4'hC);
    wait_pressed(50);
    tick(BW + 9);
    chk("mid_row_low", row, 4'b0111);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_row", row, 4'hF);
    chk("mid_rst_pressed", pressed, 0);
    chk("mid_rst_keys_sent", keys_sent, 0);
    chk("mid_rst_key_ready", key_ready, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("mid_after_busy", busy, 0);

    // Random traffic with a reset in the middle.
    rand_col = 1;
    for (int i = 0; i < 1500; i++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom);
      if (i == 700) begin
        key_valid = 1'b0;
        rst_n     = 1'b0;
      end
      if (i == 703) rst_n = 1'b1;
      tick(1);
    end
    key_valid = 1'b0;
    wait_idle(2000);

    // 256 presses wrap the counter back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) push(4'($urandom));
    wait_idle(300 * (2*BW + H + G + 2));
    chk("wrap_keys_sent", keys_sent, 0);
    rand_col = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
